// File: rtl/s2p_pkg.sv
// s2p_pkg: shared modulation modes, symbol sizing helper and counter width
// for the serial-to-parallel symbol mapper.
package s2p_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_8PSK  = 2'd2,
        MODE_16QAM = 2'd3
    } mode_e;

    localparam int SYM_CNT_W = 16;

    // Bits per symbol for a mode, clamped to the widest symbol the instance holds.
    function automatic int bits_per_sym(input mode_e mode, input int max);
        int bits;
        bits = int'(mode) + 1;
        if (bits > max) begin
            bits = max;
        end
        return bits;
    endfunction

endpackage

// File: rtl/s2p_out_slot.sv
// s2p_out_slot: one-entry valid/ready output register for finished symbols.
// A new symbol may load in the same cycle the current one drains.
module s2p_out_slot
    import s2p_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int LEN_W  = 3
) (
    input  logic              clk_8megahz,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              load_padded,
    input  logic              sym_ready,
    output logic [DATA_W-1:0] sym_data,
    output logic [LEN_W-1:0]  sym_len,
    output logic              sym_padded,
    output logic              sym_valid,
    output logic              fire,
    output logic              slot_free
);

    assign fire      = sym_valid && sym_ready;
    assign slot_free = !sym_valid || sym_ready;

    // Capture a finished symbol, or empty the slot once downstream has taken it.
    always_ff @(posedge clk_8megahz) begin
        if (rst) begin
            sym_data   <= '0;
            sym_len    <= '0;
            sym_padded <= 1'b0;
            sym_valid  <= 1'b0;
        end else if (load) begin
            sym_data   <= load_data;
            sym_len    <= load_len;
            sym_padded <= load_padded;
            sym_valid  <= 1'b1;
        end else if (fire) begin
            sym_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/s2p_mapper.sv
// s2p_mapper: packs a serial bit stream into 1..MAX_BITS-bit symbols chosen
// at run time by mode, splits even-length symbols into I/Q halves, supports
// zero-padded flush of a partial symbol and counts delivered symbols.
module s2p_mapper
    import s2p_pkg::*;
#(
    parameter int MAX_BITS  = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                             clk_8megahz,
    input  logic                             rst,
    input  logic [1:0]                       mode,
    input  logic                             bit_in,
    input  logic                             bit_valid,
    output logic                             bit_ready,
    input  logic                             flush,
    output logic [MAX_BITS-1:0]              sym_data,
    output logic [MAX_BITS/2-1:0]            sym_i,
    output logic [MAX_BITS/2-1:0]            sym_q,
    output logic [$clog2(MAX_BITS+1)-1:0]    sym_len,
    output logic                             sym_padded,
    output logic                             sym_valid,
    input  logic                             sym_ready,
    output logic [SYM_CNT_W-1:0]             sym_count
);

    localparam int LEN_W = $clog2(MAX_BITS + 1);
    localparam int HALF  = MAX_BITS / 2;

    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    cur_len;
    logic [LEN_W-1:0]    cnt_nxt;
    logic [MAX_BITS-1:0] shreg;
    logic [MAX_BITS-1:0] data_nxt;
    logic                flush_pend;
    logic                accept;
    logic                complete;
    logic                flush_req;
    logic                flush_exec;
    logic                load;
    logic                fire;
    logic                slot_free;

    assign bit_ready  = !rst && !flush_pend && slot_free;
    assign accept     = bit_valid && bit_ready;
    assign cur_len    = (cnt == '0) ? LEN_W'(bits_per_sym(mode_e'(mode), MAX_BITS)) : len;
    assign complete   = accept && (cnt_nxt == cur_len);
    assign flush_req  = flush || flush_pend;
    assign flush_exec = flush_req && slot_free && !complete;
    assign load       = complete || (flush_exec && (cnt_nxt != '0));

    // Place an accepted bit into the partial symbol; a fresh symbol starts from all zeros.
    always_comb begin
        data_nxt = (cnt == '0) ? '0 : shreg;
        cnt_nxt  = cnt;
        if (accept) begin
            for (int k = 0; k < MAX_BITS; k++) begin
                if (MSB_FIRST != 0) begin
                    if (k == int'(cur_len) - 1 - int'(cnt)) begin
                        data_nxt[k] = bit_in;
                    end
                end else if (k == int'(cnt)) begin
                    data_nxt[k] = bit_in;
                end
            end
            cnt_nxt = cnt + LEN_W'(1);
        end
    end

    // Fill counter, latched length, partial symbol and deferred flush request.
    always_ff @(posedge clk_8megahz) begin
        if (rst) begin
            cnt        <= '0;
            len        <= '0;
            shreg      <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (accept && (cnt == '0)) begin
                len <= cur_len;
            end
            cnt        <= load ? '0 : cnt_nxt;
            shreg      <= load ? '0 : data_nxt;
            flush_pend <= flush_req && !slot_free;
        end
    end

    s2p_out_slot #(
        .DATA_W (MAX_BITS),
        .LEN_W  (LEN_W)
    ) u_out_slot (
        .clk_8megahz (clk_8megahz),
        .rst         (rst),
        .load        (load),
        .load_data   (data_nxt),
        .load_len    (cur_len),
        .load_padded (!complete),
        .sym_ready   (sym_ready),
        .sym_data    (sym_data),
        .sym_len     (sym_len),
        .sym_padded  (sym_padded),
        .sym_valid   (sym_valid),
        .fire        (fire),
        .slot_free   (slot_free)
    );

    // Count every symbol handed to downstream; wraps silently.
    always_ff @(posedge clk_8megahz) begin
        if (rst) begin
            sym_count <= '0;
        end else if (fire) begin
            sym_count <= sym_count + SYM_CNT_W'(1);
        end
    end

    // Split even-length symbols into right-justified upper (I) and lower (Q) halves.
    always_comb begin
        sym_i = '0;
        sym_q = '0;
        if (sym_len[0] == 1'b0) begin
            for (int k = 0; k < HALF; k++) begin
                if (k < int'(sym_len) / 2) begin
                    sym_q[k] = sym_data[k];
                    for (int j = 0; j < MAX_BITS; j++) begin
                        if (j == int'(sym_len) / 2 + k) begin
                            sym_i[k] = sym_data[j];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_s2p_mapper.sv
// tb_s2p_mapper: directed self-checking bench for s2p_mapper (MAX_BITS=4),
// with an LSB-first instance sharing the same stimulus.
module tb_s2p_mapper;
    import s2p_pkg::*;

    logic        clk_8megahz = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        bit_in;
    logic        bit_valid;
    logic        flush;
    logic        sym_ready;

    logic        bit_ready;
    logic [3:0]  sym_data;
    logic [1:0]  sym_i;
    logic [1:0]  sym_q;
    logic [2:0]  sym_len;
    logic        sym_padded;
    logic        sym_valid;
    logic [15:0] sym_count;

    logic        lsb_bit_ready;
    logic [3:0]  lsb_sym_data;
    logic [1:0]  lsb_sym_i;
    logic [1:0]  lsb_sym_q;
    logic [2:0]  lsb_sym_len;
    logic        lsb_sym_padded;
    logic        lsb_sym_valid;
    logic [15:0] lsb_sym_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int guard;

    always #5 clk_8megahz = ~clk_8megahz;

    s2p_mapper #(.MAX_BITS(4), .MSB_FIRST(1)) dut (
        .clk_8megahz (clk_8megahz), .rst (rst), .mode (mode),
        .bit_in (bit_in), .bit_valid (bit_valid), .bit_ready (bit_ready),
        .flush (flush), .sym_data (sym_data), .sym_i (sym_i), .sym_q (sym_q),
        .sym_len (sym_len), .sym_padded (sym_padded), .sym_valid (sym_valid),
        .sym_ready (sym_ready), .sym_count (sym_count)
    );

    s2p_mapper #(.MAX_BITS(4), .MSB_FIRST(0)) dut_lsb (
        .clk_8megahz (clk_8megahz), .rst (rst), .mode (mode),
        .bit_in (bit_in), .bit_valid (bit_valid), .bit_ready (lsb_bit_ready),
        .flush (flush), .sym_data (lsb_sym_data), .sym_i (lsb_sym_i), .sym_q (lsb_sym_q),
        .sym_len (lsb_sym_len), .sym_padded (lsb_sym_padded), .sym_valid (lsb_sym_valid),
        .sym_ready (sym_ready), .sym_count (lsb_sym_count)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic b, input logic f);
        bit_valid = v;
        bit_in    = b;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge clk_8megahz);
        #1;
    endtask

    // Hard stop in case a wait never resolves.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; mode = 2'd0; sym_ready = 1'b0;
        apply_stimulus(0, 0, 0);
        tick(); tick();
        check_output("rst_valid", 32'(sym_valid), 0);
        check_output("rst_data", 32'(sym_data), 0);
        check_output("rst_len", 32'(sym_len), 0);
        check_output("rst_padded", 32'(sym_padded), 0);
        check_output("rst_count", 32'(sym_count), 0);
        check_output("rst_ready", 32'(bit_ready), 0);
        rst = 1'b0;
        #1;
        check_output("idle_ready", 32'(bit_ready), 1);

        // QPSK back-to-back 1,0,1,1
        mode = 2'd1; sym_ready = 1'b1;
        apply_stimulus(1, 1, 0); #1; check_output("qpsk_rdy0", 32'(bit_ready), 1); tick();
        apply_stimulus(1, 0, 0); #1; check_output("qpsk_rdy1", 32'(bit_ready), 1); tick();
        check_output("qpsk_a_valid", 32'(sym_valid), 1);
        check_output("qpsk_a_data", 32'(sym_data), 2);
        check_output("qpsk_a_len", 32'(sym_len), 2);
        check_output("qpsk_a_i", 32'(sym_i), 1);
        check_output("qpsk_a_q", 32'(sym_q), 0);
        apply_stimulus(1, 1, 0); #1; check_output("qpsk_rdy2", 32'(bit_ready), 1); tick();
        apply_stimulus(1, 1, 0); #1; check_output("qpsk_rdy3", 32'(bit_ready), 1); tick();
        check_output("qpsk_b_data", 32'(sym_data), 3);
        check_output("qpsk_b_i", 32'(sym_i), 1);
        check_output("qpsk_b_q", 32'(sym_q), 1);
        apply_stimulus(0, 0, 0); tick();
        check_output("qpsk_count", 32'(sym_count), 2);
        check_output("qpsk_drained", 32'(sym_valid), 0);

        // 16QAM 1,0,1,1 on both bit orders
        mode = 2'd3;
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 0, 0); tick();
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 1, 0); tick();
        check_output("qam_data", 32'(sym_data), 4'hB);
        check_output("qam_i", 32'(sym_i), 2);
        check_output("qam_q", 32'(sym_q), 3);
        check_output("qam_len", 32'(sym_len), 4);
        check_output("qam_padded", 32'(sym_padded), 0);
        check_output("qam_lsb_data", 32'(lsb_sym_data), 4'hD);
        apply_stimulus(0, 0, 0); tick();
        check_output("qam_count", 32'(sym_count), 3);

        // 8PSK 1,1 then flush
        mode = 2'd2;
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 1, 0); tick();
        check_output("psk8_partial_valid", 32'(sym_valid), 0);
        apply_stimulus(0, 0, 1); tick();
        check_output("flush_valid", 32'(sym_valid), 1);
        check_output("flush_data", 32'(sym_data), 6);
        check_output("flush_len", 32'(sym_len), 3);
        check_output("flush_padded", 32'(sym_padded), 1);
        check_output("flush_i", 32'(sym_i), 0);
        check_output("flush_q", 32'(sym_q), 0);
        apply_stimulus(0, 0, 0); tick();
        check_output("flush_count", 32'(sym_count), 4);

        // Flush with nothing collected
        apply_stimulus(0, 0, 1); tick();
        apply_stimulus(0, 0, 0);
        check_output("empty_flush_valid", 32'(sym_valid), 0);
        tick();
        check_output("empty_flush_valid2", 32'(sym_valid), 0);
        check_output("empty_flush_count", 32'(sym_count), 4);

        // Flush in the same cycle as the completing bit
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 0, 0); tick();
        apply_stimulus(1, 1, 1); tick();
        check_output("same_cyc_data", 32'(sym_data), 5);
        check_output("same_cyc_padded", 32'(sym_padded), 0);
        apply_stimulus(0, 0, 0); tick();
        check_output("same_cyc_count", 32'(sym_count), 5);
        check_output("same_cyc_no_extra", 32'(sym_valid), 0);

        // Mode change mid-symbol
        mode = 2'd1;
        apply_stimulus(1, 0, 0); tick();
        mode = 2'd3;
        apply_stimulus(1, 1, 0); tick();
        check_output("mchg_a_data", 32'(sym_data), 1);
        check_output("mchg_a_len", 32'(sym_len), 2);
        check_output("mchg_a_q", 32'(sym_q), 1);
        apply_stimulus(1, 0, 0); tick();
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 0, 0); tick();
        check_output("mchg_b_data", 32'(sym_data), 6);
        check_output("mchg_b_len", 32'(sym_len), 4);
        check_output("mchg_b_i", 32'(sym_i), 1);
        check_output("mchg_b_q", 32'(sym_q), 2);
        apply_stimulus(0, 0, 0); tick();
        check_output("mchg_count", 32'(sym_count), 7);

        // Backpressure stall with a flush arriving mid-stall
        mode = 2'd1; sym_ready = 1'b0;
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 0, 0); tick();
        check_output("stall_valid", 32'(sym_valid), 1);
        apply_stimulus(1, 0, 0);
        for (int c = 0; c < 10; c++) begin
            flush = (c == 4);
            #1;
            check_output("stall_ready", 32'(bit_ready), 0);
            check_output("stall_data", 32'(sym_data), 2);
            tick();
        end
        flush = 1'b0;
        sym_ready = 1'b1;
        #1;
        check_output("release_pend_ready", 32'(bit_ready), 0);
        tick();
        check_output("release_valid", 32'(sym_valid), 0);
        check_output("release_count", 32'(sym_count), 8);
        apply_stimulus(1, 0, 0); #1; check_output("resume_ready", 32'(bit_ready), 1); tick();
        apply_stimulus(1, 1, 0); tick();
        check_output("resume_s0", 32'(sym_data), 1);
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 1, 0); tick();
        check_output("resume_s1", 32'(sym_data), 3);
        apply_stimulus(1, 0, 0); tick();
        apply_stimulus(1, 0, 0); tick();
        check_output("resume_s2", 32'(sym_data), 0);
        check_output("resume_s2_valid", 32'(sym_valid), 1);
        apply_stimulus(0, 0, 0); tick();
        check_output("resume_count", 32'(sym_count), 11);

        // Reset after one bit of a 16QAM symbol
        mode = 2'd3;
        apply_stimulus(1, 1, 0); tick();
        rst = 1'b1;
        apply_stimulus(0, 0, 0); tick();
        check_output("midrst_valid", 32'(sym_valid), 0);
        check_output("midrst_data", 32'(sym_data), 0);
        check_output("midrst_count", 32'(sym_count), 0);
        check_output("midrst_ready", 32'(bit_ready), 0);
        rst = 1'b0;
        apply_stimulus(1, 0, 0); tick();
        apply_stimulus(1, 1, 0); tick();
        apply_stimulus(1, 0, 0); tick();
        apply_stimulus(1, 1, 0); tick();
        check_output("postrst_data", 32'(sym_data), 5);
        check_output("postrst_len", 32'(sym_len), 4);
        check_output("postrst_padded", 32'(sym_padded), 0);
        check_output("postrst_count0", 32'(sym_count), 0);
        apply_stimulus(0, 0, 0); tick();
        check_output("postrst_count1", 32'(sym_count), 1);

        // Counter wrap using one-bit BPSK symbols at full rate
        mode = 2'd0;
        apply_stimulus(1, 1, 0);
        guard = 0;
        while (sym_count != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        check_output("wrap_reach", 32'(sym_count), 32'hFFFF);
        check_output("wrap_no_bubble", 32'(sym_valid), 1);
        apply_stimulus(0, 0, 0); tick();
        check_output("wrap_zero", 32'(sym_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/s2p_mapper.md
# s2p_mapper

Parametrised serial-to-parallel symbol mapper: the next generation of the fixed QPSK splitter. It runs on the single 8 MHz system clock, with valid/ready handshakes instead of divided 2 MHz/1 MHz clocks. It packs an incoming serial bit stream into symbols of 1–MAX_BITS bits, with the size selected at run time by `mode` (BPSK/QPSK/8PSK/16QAM), and presents each symbol with I/Q halves to the downstream constellation mapper. It also supports zero-padded flush of a partial symbol and counts emitted symbols.

## Interface
- `MAX_BITS`, default 4: maximum bits per symbol; even, ≥2.
- `MSB_FIRST`, default 1: 1 = first received bit lands in the symbol MSB; 0 = LSB.
- `clk_8megahz` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mode` in 2: bits per symbol = mode+1, clamped to MAX_BITS; 0 BPSK, 1 QPSK, 2 8PSK, 3 16QAM.
- `bit_in` in 1: serial data bit.
- `bit_valid` in 1: bit_in is valid.
- `bit_ready` out 1: block accepts a bit this cycle.
- `flush` in 1: one-cycle pulse; emit the current partial symbol, zero-padded.
- `sym_data` out MAX_BITS: packed symbol, right-justified.
- `sym_i` out MAX_BITS/2: upper half of symbol (even lengths), else 0.
- `sym_q` out MAX_BITS/2: lower half of symbol (even lengths), else 0.
- `sym_len` out $clog2(MAX_BITS+1): symbol length latched with the symbol.
- `sym_padded` out 1: symbol was produced by flush.
- `sym_valid` out 1: output slot holds a symbol.
- `sym_ready` in 1: downstream takes the symbol.
- `sym_count` out 16: symbols emitted (handshaken); wraps 0xFFFF→0.

## Operation
- **Bit accept:** bit accepted when `bit_valid && bit_ready`. `bit_ready = !rst && !flush_pend && !(sym_valid && !sym_ready)`.
- **Fill counter `cnt`** (0..len-1):
  - `cnt==0` on accept: latch `len = min(mode+1, MAX_BITS)`. Mode changes mid-symbol are ignored.
  - Bit placement: MSB_FIRST=1 writes the bit to position len-1-cnt; MSB_FIRST=0 writes it to position cnt.
- **Completion:** accepting bit number len loads the output slot and sets `sym_padded=0`, `sym_valid=1`. `cnt` returns to 0.
- **I/Q split:** for even len, `sym_i = sym_data[len-1:len/2]` and `sym_q = sym_data[len/2-1:0]`, both right-justified. For odd len, sym_i and sym_q are 0.
- **Flush:**
  - `cnt>0`: the partial symbol is emitted with unfilled positions 0, `sym_len=len`, `sym_padded=1`.
  - `cnt==0`: no effect.
  - Output slot occupied and not draining: flush is latched in `flush_pend` and executes on the first cycle the slot frees. bit_ready stays 0 while it is pending.
  - Bit accepted in the same cycle as flush: the bit is included first, then flushed. If that bit completes the symbol, it is a normal, unpadded symbol and the flush is a no-op.
- **Output slot:** holds its value while `sym_valid && !sym_ready`. On `sym_valid && sym_ready`, `sym_count` increments. A new symbol may load in that same cycle, giving full throughput.

## Timing
- **Reset:** while `rst` is high, all registers clear on the next edge. Reset values: sym_valid 0, sym_data/i/q 0, sym_len 0, sym_padded 0, sym_count 0, bit_ready 0. Internal `cnt` and flush_pend are also 0.
- **Reset mid-symbol:** the partial symbol is discarded and never emitted. An occupied output slot is dropped.
- **Latency:** sym_valid rises the cycle after the last bit of a symbol is accepted, or the cycle after flush executes.
- **Throughput:** one bit per cycle, with no bubble between symbols when sym_ready is held high.
- **Backpressure:** bit_ready falls combinationally from `sym_ready` while the slot is full. No bits are lost or duplicated.
- **Counter wrap:** sym_count wraps silently; there is no saturation.

## Structure
- **Package `s2p_pkg`:**
  - `mode_e` enum: MODE_BPSK=0, MODE_QPSK=1, MODE_8PSK=2, MODE_16QAM=3.
  - Function `bits_per_sym(mode, max)`.
  - Constant `SYM_CNT_W=16`.
- **Sub-module `s2p_out_slot`:** one-entry valid/ready output register holding data/len/padded. It provides the fire signal for sym_count.
- **Top level:** fill counter, shift/placement logic and flush-pending flag.

## Test plan
- QPSK, MSB_FIRST=1, bits 1,0,1,1 back-to-back, sym_ready=1 → two symbols: sym_data=2'b10 (i=1, q=0), then 2'b11 (i=1, q=1). sym_count=2; no bubbles.
- 16QAM, bits 1,0,1,1 → sym_data=4'b1011, sym_i=2'b10, sym_q=2'b11, sym_len=4. Repeat with MSB_FIRST=0 → sym_data=4'b1101.
- 8PSK, bits 1,1 then flush → sym_data=3'b110, sym_len=3, sym_padded=1, sym_i=sym_q=0. Flush with cnt==0 → no sym_valid.
- Mode change from QPSK to 16QAM after the first bit → current symbol still 2 bits. Next symbol is 4 bits.
- sym_ready=0 for 10 cycles with continuous bit_valid → one symbol held stable and bit_ready=0. On release, no bit is lost; sequence checked against a reference model. Flush during the stall executes on release.
- rst pulse after 1 bit of a 16QAM symbol → outputs 0 the next cycle. The following 4 bits form a clean symbol; sym_count restarts at 0 and wraps at 65536 symbols.
